execute_cycle: RTL
==================

Name: execute_cycle

Overview:
Execute stage of the 5-stage RV32I pipeline. It consumes the ID/EX pipeline register outputs of the decode stage and applies the forwarding muxes selected by the hazard unit. It runs the ALU, resolves branches and jumps (PCSrcE, PCTargetE back to fetch), and holds the EX/MEM pipeline register feeding the memory stage.

Parameters:
XLEN, 32, datapath width (only 32 is supported)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears the EX/MEM register
RegWriteE  in  1  register-write control from ID/EX
ResultSrcE  in  2  writeback select from ID/EX (00 ALU, 01 mem, 10 PC+4)
MemWriteE  in  1  store enable from ID/EX
JumpE  in  1  jal marker
BranchE  in  1  beq marker
ALUControlE  in  3  ALU op
ALUSrcE  in  1  0: SrcB = forwarded RD2; 1: SrcB = ImmExtE
RD1E, RD2E  in  32 each  register operands from ID/EX
PCE  in  32  PC of the instruction in EX
ImmExtE  in  32  sign-extended immediate
RdE  in  5  destination register
PCPlus4E  in  32  PC+4 of the instruction in EX
ForwardAE, ForwardBE  in  2 each  forward selects from the hazard unit
ResultW  in  32  writeback-stage result, used for forwarding
PCSrcE  out  1  redirect fetch (combinational)
PCTargetE  out  32  branch/jump target (combinational)
RegWriteM, MemWriteM  out  1 each  registered controls
ResultSrcM  out  2  registered control
ALUResultM  out  32  registered ALU result; also forwarded internally
WriteDataM  out  32  registered store data
RdM  out  5  registered destination register
PCPlus4M  out  32  registered PC+4

Behaviour:
- Forward mux A/B: 00 selects RD1E/RD2E; 01 selects ResultW; 10 selects ALUResultM (current EX/MEM register output); 11 is reserved and behaves as 00.
- SrcA = forwarded A. SrcB = ALUSrcE ? ImmExtE : forwarded B.
- ALU ops: 000 add; 001 sub; 010 and; 011 or; 101 signed slt (result 1 or 0). Any other code gives a result of 0.
- All ALU arithmetic wraps modulo 2^32. Overflow is not flagged.
- ZeroE = (ALU result == 0).
- PCTargetE = PCE + ImmExtE, wrapping modulo 2^32.
- PCSrcE = JumpE | (BranchE & ZeroE). It is purely combinational, with zero-cycle latency, and is valid every cycle.
- EX/MEM register, updated on each rising edge:
  - if reset=1: RegWriteM=0, MemWriteM=0, ResultSrcM=00, ALUResultM=0, WriteDataM=0, RdM=0, PCPlus4M=0.
  - else it captures RegWriteE, MemWriteE, ResultSrcE, the ALU result, forwarded B (never the immediate), RdE and PCPlus4E.
- Latency: EX inputs appear on the M outputs one cycle later.
- No stall or flush input. A flushed instruction arrives as an all-zero bubble from decode and propagates as a bubble (RegWriteM=0, MemWriteM=0).
- Reset mid-stream: the next edge produces a bubble in M regardless of the EX inputs. PCSrcE still follows its inputs combinationally.
- Back-to-back dependency: with ForwardAE=10, the ALU consumes the previous cycle's ALUResultM in the same cycle.
- No internal forwarding decisions: the selects come only from the hazard unit.

Decomposition:
- Shared package holds:
  - ALU op constants: ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101.
  - Forward-select constants: FWD_REG=00, FWD_WB=01, FWD_MEM=10.
  - ResultSrc constants.
- One sub-module, alu: combinational, inputs SrcA, SrcB, ALUControl; outputs Result and Zero.
- Forwarding muxes and the EX/MEM register stay in execute_cycle.

Test Plan:
- Add/sub/slt: RD1E=5, RD2E=7, ALUSrcE=0, forwards 00, codes 000/001/101. Required: ALUResultM = 12, then 0xFFFFFFFE, then 1 on the following edges. Signed slt with RD1E=0x80000000, RD2E=1 gives 1.
- Forwarding: ForwardAE=10 with ALUResultM=0x100, RD1E=0, ImmExtE=4, ALUSrcE=1, add. Required next ALUResultM=0x104. With ForwardBE=01, ResultW=0x55, ALUSrcE=1, ImmExtE=8, the result is unaffected and WriteDataM=0x55.
- Branch: BranchE=1, sub, RD1E=RD2E=9, PCE=0x40, ImmExtE=0xFFFFFFF8. Required: PCSrcE=1 and PCTargetE=0x38 the same cycle. With RD2E=8, PCSrcE=0.
- Jump: JumpE=1, ResultSrcE=10, PCPlus4E=0x24, RdE=1. Required: PCSrcE=1 and, next edge, PCPlus4M=0x24, RdM=1, RegWriteM=1.
- Reset: hold reset=1 while feeding a store (MemWriteE=1, RegWriteE=1). Required: every M output is 0 after the edge. Releasing reset lets the next instruction pass normally.
- Illegal op and wrap: ALUControlE=111 gives ALUResultM=0. Add of 0xFFFFFFFF+1 gives 0, and ZeroE-gated beq is taken.

Source files
------------

// File: rtl/execute_cycle_pkg.sv
// Shared constants and types for the RV32I execute stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package execute_cycle_pkg;

    // Datapath width; the stage is only defined for RV32.
    localparam int XLEN_P = 32;

    // ALU operation encodings driven by the decode stage.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Forward selects from the hazard unit. 2'b11 is reserved and falls back
    // to the register-file operand.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Writeback source selects, carried through EX untouched.
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // EX/MEM pipeline register contents. An all-zero value is a bubble.
    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic [1:0]        result_src;
        logic [XLEN_P-1:0] alu_result;
        logic [XLEN_P-1:0] write_data;
        logic [4:0]        rd;
        logic [XLEN_P-1:0] pc_plus4;
    } exmem_t;

    // Operand forwarding mux; any select other than WB/MEM uses the register value.
    function automatic logic [XLEN_P-1:0] fwd_mux(
        input logic [1:0]        sel,
        input logic [XLEN_P-1:0] reg_val,
        input logic [XLEN_P-1:0] wb_val,
        input logic [XLEN_P-1:0] mem_val
    );
        logic [XLEN_P-1:0] v;
        case (sel)
            FWD_WB:  v = wb_val;
            FWD_MEM: v = mem_val;
            default: v = reg_val;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/execute_cycle_alu.sv
// RV32I execute-stage ALU: add/sub/and/or/signed-slt, zero flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result is valid whenever operands are.
module execute_cycle_alu
    import execute_cycle_pkg::*;
(
    input  logic [XLEN_P-1:0] SrcA,
    input  logic [XLEN_P-1:0] SrcB,
    input  logic [2:0]        ALUControl,
    output logic [XLEN_P-1:0] Result,
    output logic              Zero
);

    // Operation select; arithmetic wraps naturally at 32 bits, unknown codes yield 0.
    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = SrcA + SrcB;
            ALU_SUB: Result = SrcA - SrcB;
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_SLT: Result = {{(XLEN_P-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolve, EX/MEM register.
// Latency: PCSrcE/PCTargetE combinational; M outputs one cycle after EX inputs.
// Backpressure: none; no stall or flush, a flushed slot arrives as an all-zero bubble.
module execute_cycle
    import execute_cycle_pkg::*;
#(
    parameter int XLEN = XLEN_P
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic [2:0]      ALUControlE,
    input  logic            ALUSrcE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [4:0]      RdE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] PCPlus4M
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            zero;
    exmem_t          exmem_d;
    exmem_t          exmem_q;

    // Forwarding muxes; the MEM path feeds back the EX/MEM register output so a
    // dependent instruction directly behind its producer sees the fresh result.
    always_comb begin
        src_a = fwd_mux(ForwardAE, RD1E, ResultW, exmem_q.alu_result);
        fwd_b = fwd_mux(ForwardBE, RD2E, ResultW, exmem_q.alu_result);
        src_b = ALUSrcE ? ImmExtE : fwd_b;
    end

    execute_cycle_alu u_alu (
        .SrcA       (src_a),
        .SrcB       (src_b),
        .ALUControl (ALUControlE),
        .Result     (alu_result),
        .Zero       (zero)
    );

    // Branch/jump resolution goes straight back to fetch in the same cycle.
    assign PCTargetE = PCE + ImmExtE;
    assign PCSrcE    = JumpE | (BranchE & zero);

    // Next EX/MEM contents; store data is always the forwarded rs2, never the immediate.
    always_comb begin
        exmem_d            = '0;
        exmem_d.reg_write  = RegWriteE;
        exmem_d.mem_write  = MemWriteE;
        exmem_d.result_src = ResultSrcE;
        exmem_d.alu_result = alu_result;
        exmem_d.write_data = fwd_b;
        exmem_d.rd         = RdE;
        exmem_d.pc_plus4   = PCPlus4E;
    end

    // EX/MEM register; reset inserts a bubble regardless of the EX inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    assign RegWriteM  = exmem_q.reg_write;
    assign MemWriteM  = exmem_q.mem_write;
    assign ResultSrcM = exmem_q.result_src;
    assign ALUResultM = exmem_q.alu_result;
    assign WriteDataM = exmem_q.write_data;
    assign RdM        = exmem_q.rd;
    assign PCPlus4M   = exmem_q.pc_plus4;

endmodule
